// File: rtl/disp_scan_pkg.sv
// disp_pkg: shared constants and segment table for the seven-segment scanner
package disp_pkg;
  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [7:0] AN_OFF = 8'hFF;
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/disp_scan_if.sv
// disp_scan_if: display word/control inputs and multiplexed pin outputs
interface disp_scan_if;
  logic [31:0] disp_data;
  logic freeze;
  logic blank_lz;
  logic [7:0] dp_mask;
  logic [7:0] an;
  logic [6:0] seg;
  logic dp;
  modport master(output disp_data, freeze, blank_lz, dp_mask, input an, seg, dp);
  modport slave(input disp_data, freeze, blank_lz, dp_mask, output an, seg, dp);
endinterface

// File: rtl/disp_scan_hex7seg.sv
// hex7seg: nibble to active-low seven-segment decode
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = SEG_TABLE[nib];
endmodule

// File: rtl/disp_scan.sv
// disp_scan: time-multiplexed eight-digit hex display driver with leading-zero blanking
module disp_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 100000
) (
  input logic clk,
  input logic rst,
  disp_scan_if.slave bus
);
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [31:0] shadow;
  logic [3:0] nib;
  logic [6:0] dec;
  logic tick, blank;
  always_comb begin
    tick = cnt == LAST;
    nib = shadow[{idx, 2'b00} +: 4];
    blank = bus.blank_lz && idx != '0 && (shadow >> {idx, 2'b00}) == 32'd0;
  end
  hex7seg u_dec (.nib(nib), .seg(dec));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      shadow <= '0;
      bus.an <= AN_OFF;
      bus.seg <= SEG_BLANK;
      bus.dp <= 1'b1;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= idx + IW'(tick);
      shadow <= bus.freeze ? shadow : bus.disp_data;
      bus.an <= blank ? AN_OFF : ~(8'b1 << idx);
      bus.seg <= blank ? SEG_BLANK : dec;
      bus.dp <= blank | ~bus.dp_mask[idx];
    end
  end
endmodule

// File: tb/tb_disp_scan.sv
// tb_disp_scan: scoreboard bench comparing two scan rates against a cycle-count reference model
module tb_disp_scan;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  disp_scan_if if4 ();
  disp_scan_if if1 ();
  assign if1.disp_data = if4.disp_data;
  assign if1.freeze = if4.freeze;
  assign if1.blank_lz = if4.blank_lz;
  assign if1.dp_mask = if4.dp_mask;
  disp_scan #(.SCAN_DIV(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));
  disp_scan #(.SCAN_DIV(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
  always #5 clk = ~clk;
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  function automatic logic [15:0] model_out(input logic [31:0] word, input int d,
                                            input logic blz, input logic [7:0] dpm);
    logic [31:0] upper;
    logic [7:0] an;
    upper = word >> (4 * d);
    if (blz && d != 0 && upper == 0) return {8'hFF, 7'h7F, 1'b1};
    an = 8'hFF;
    an[d] = 1'b0;
    return {an, hex_tab[upper[3:0]], ~dpm[d]};
  endfunction
  logic [15:0] q4[$], q1[$];
  logic [31:0] m_shadow;
  int m_cyc;
  always @(posedge clk) begin
    if (rst) begin
      q4.push_back({8'hFF, 7'h7F, 1'b1});
      q1.push_back({8'hFF, 7'h7F, 1'b1});
      m_shadow = 0;
      m_cyc = 0;
    end else begin
      q4.push_back(model_out(m_shadow, (m_cyc / 4) % 8, if4.blank_lz, if4.dp_mask));
      q1.push_back(model_out(m_shadow, m_cyc % 8, if4.blank_lz, if4.dp_mask));
      if (!if4.freeze) m_shadow = if4.disp_data;
      m_cyc++;
    end
  end
  always @(negedge clk) begin
    logic [15:0] e;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      checks++;
      if ({if4.an, if4.seg, if4.dp} !== e) begin
        errors++;
        $display("FAIL div4 t=%0t an/seg/dp got %h/%h/%b expected %h/%h/%b", $time,
                 if4.an, if4.seg, if4.dp, e[15:8], e[7:1], e[0]);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      checks++;
      if ({if1.an, if1.seg, if1.dp} !== e) begin
        errors++;
        $display("FAIL div1 t=%0t an/seg/dp got %h/%h/%b expected %h/%h/%b", $time,
                 if1.an, if1.seg, if1.dp, e[15:8], e[7:1], e[0]);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst = 1'b1;
    if4.disp_data = 32'h0;
    if4.freeze = 1'b0;
    if4.blank_lz = 1'b0;
    if4.dp_mask = 8'h00;
    step(3);
    rst = 1'b0;
    if4.disp_data = 32'h76543210;
    step(40);
    if4.disp_data = 32'hFEDCBA98;
    if4.dp_mask = 8'h01;
    step(40);
    if4.disp_data = 32'h12345678;
    step(5);
    if4.freeze = 1'b1;
    if4.disp_data = 32'hDEADBEEF;
    step(40);
    if4.freeze = 1'b0;
    step(40);
    if4.blank_lz = 1'b1;
    if4.dp_mask = 8'hFF;
    if4.disp_data = 32'h000000A0;
    step(36);
    if4.disp_data = 32'h0;
    step(36);
    for (int k = 0; k < 64 && ((m_cyc / 4) % 8) != 5; k++) step(1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    if4.disp_data = 32'h00ABC000;
    step(40);
    for (int k = 0; k < 400; k++) begin
      if4.disp_data = $urandom >> $urandom_range(0, 32);
      if4.freeze = $urandom_range(0, 3) == 0;
      if4.blank_lz = $urandom_range(0, 1) == 1;
      if4.dp_mask = 8'($urandom);
      rst = $urandom_range(0, 60) == 0;
      step($urandom_range(1, 6));
    end
    rst = 1'b0;
    step(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/disp_scan.md
# disp_scan

Board-level display driver that consumes the 32-bit debug word read out of the single-cycle CPU's register file (the value selected by `reg_sel`) and shows it as eight hexadecimal digits on a time-multiplexed, active-low seven-segment display. It holds a shadow copy of the word, rotates through the digits at a programmable refresh rate, decodes each nibble, and optionally blanks leading zeros. It sits between the CPU top's `reg_data` output and the board pins.

## Interface
- `SCAN_DIV`, 100000: clock cycles per digit slot; legal range ≥1 (1 kHz per digit at 100 MHz).
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `disp_data`  in  32  word to display; normally the CPU top's `reg_data`.
- `freeze`  in  1  1 = hold the shadow word; 0 = shadow tracks `disp_data` every cycle.
- `blank_lz`  in  1  1 = enable leading-zero blanking.
- `dp_mask`  in  8  bit i = 1 lights the decimal point of digit i.
- `an`  out  8  digit anodes, active-low; bit i drives digit i (digit 0 = least significant nibble).
- `seg`  out  7  segments, active-low; `seg[0]`=a … `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.

## Operation
- Shadow register `shadow[31:0]`: loads `disp_data` on each cycle where `freeze`=0; holds otherwise. Reset value is 0.
- Divider `cnt`: counts 0..SCAN_DIV-1, then wraps to 0. `tick` = (`cnt`==SCAN_DIV-1). With SCAN_DIV=1, `tick` is asserted every cycle. Counter width is max(1, clog2(SCAN_DIV)).
- Digit index `idx[2:0]`: increments on `tick` and wraps 7→0. No other state; scan order is fixed at 0,1,…,7,0.
- Nibble select: `nib` = `shadow[4*idx+3 : 4*idx]`.
- Blank condition for digit i: `blank_lz`=1 AND i≠0 AND `shadow[31:4*i]`==0. Digit 0 is never blanked, so a zero word shows a single "0".
- Output register, updated every cycle:
  - `an` has only bit `idx` low; it is 8'hFF when the current digit is blanked.
  - `seg` is the decode of `nib`, or 7'h7F when blanked.
  - `dp` is `~dp_mask[idx]`, or 1 when blanked.
- Decode, active-low, written g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Reset: `cnt`=0, `idx`=0, `shadow`=0, `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- Reset asserted mid-scan forces all of the reset values on the next edge, whatever the current `cnt`/`idx`.

## Timing
- All outputs are registered; there is no combinational path from any input to any pin.
- Latency from `disp_data` to pins: 2 cycles. Cycle 1 loads `shadow`; cycle 2 loads the output register.
- Latency from an `idx` change to `an`/`seg`: 1 cycle. Each digit is therefore driven for exactly SCAN_DIV cycles, with the slot boundaries shifted by one cycle.
- First cycle after `rst` deasserts: the output register loads digit 0 of `shadow`, which is 0 on that first edge.
- `freeze` rising in the same cycle that `disp_data` changes: the new value is not captured, because the shadow loads only when `freeze`=0 at the edge.
- Changes to `blank_lz` and `dp_mask` take effect in 1 cycle.

## Structure
- Package `disp_pkg` holds:
  - `NUM_DIGITS`=8
  - `SEG_BLANK`=7'h7F
  - `AN_OFF`=8'hFF
  - the 16-entry segment constant table
- Sub-module `hex7seg`: purely combinational, 4-bit nibble in, 7-bit active-low segments out. It is instantiated once on `nib`.
- `disp_scan` contains the shadow register, divider, index, blank logic and output register.

## Test plan
- Reset: hold `rst` for 3 cycles with SCAN_DIV=4 → `an`=FF, `seg`=7F, `dp`=1 during reset. After release, `an`=FE.
- Scan order: SCAN_DIV=4, `disp_data`=32'h76543210, `freeze`=0, `blank_lz`=0 → `an` steps FE,FD,FB,…,7F,FE, 4 cycles each. `seg` matches 0..7 in order.
- Decode: `disp_data`=32'hFEDCBA98 → digits 0..7 show 8,9,A,b,C,d,E,F with the exact codes above. `dp_mask`=8'h01 → `dp`=0 only while `an`=FE.
- Freeze: load 32'h12345678, set `freeze`=1, drive 32'hDEADBEEF → display still shows 12345678. Drop `freeze` → DEADBEEF appears within 2 cycles.
- Leading zeros: `blank_lz`=1, word 32'h000000A0 → digits 0,1 lit ("A0"), digits 2..7 have `an`=FF. Word 0 → only digit 0 lit, showing "0".
- Reset mid-scan and SCAN_DIV=1: assert `rst` at `idx`=5 → next `an`=FF, and digit 0 follows release. With SCAN_DIV=1, `idx` advances every cycle.
